harris_corner_extractor: RTL

- Consumes the raster-order Harris score stream from the pipelined Harris corner block and turns it into a list of corner records (x, y, score).
- Keeps row and column counters for the stream, applies a programmable threshold and 1-D horizontal non-maximum suppression, and buffers the results in a FIFO.
- Downstream reads the FIFO through a valid/ready handshake; it is the read end of the score stream.

---
 rtl/harris_corner_extractor_if.sv | 25 ++
 rtl/harris_corner_extractor.sv | 133 +++++++++++++
 2 files changed

// File: rtl/harris_corner_extractor_if.sv
// Stream bundle for the corner extractor: raster score beats in, corner records out.
// Ports: in_valid/in_score (upstream, never stalled); out_valid/out_ready handshake
//        carrying out_x/out_y/out_score (show-ahead head of the record FIFO).
interface harris_corner_extractor_if #(
   parameter int SCORE_BITS = 16,
   parameter int COORD_BITS = 16
);
   logic                  in_valid;
   logic [SCORE_BITS-1:0] in_score;
   logic                  out_valid;
   logic                  out_ready;
   logic [COORD_BITS-1:0] out_x;
   logic [COORD_BITS-1:0] out_y;
   logic [SCORE_BITS-1:0] out_score;

   // master drives the score stream and consumes records; slave is the extractor
   modport master (
      output in_valid, in_score, out_ready,
      input  out_valid, out_x, out_y, out_score
   );
   modport slave (
      input  in_valid, in_score, out_ready,
      output out_valid, out_x, out_y, out_score
   );
endinterface

// File: rtl/harris_corner_extractor.sv
// Turns a raster Harris score stream into (x, y, score) corner records via threshold + 1-D horizontal NMS.
// Latency: record decided on the beat after its column; out_valid rises one cycle after the FIFO write.
// Backpressure: input never stalls; records wait in the FIFO, and a full FIFO drops and counts them.
// Ports: clk, reset (async high); r_row_length/r_num_rows/r_threshold geometry and threshold;
//        bus (slave) score stream in and record handshake out; frame_done pulse; dropped_count.
module harris_corner_extractor #(
   parameter int SCORE_BITS = 16,
   parameter int COORD_BITS = 16,
   parameter int FIFO_DEPTH = 16,
   parameter int DROP_BITS  = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [COORD_BITS-1:0] r_row_length,
   input  logic [COORD_BITS-1:0] r_num_rows,
   input  logic [SCORE_BITS-1:0] r_threshold,
   harris_corner_extractor_if.slave bus,
   output logic                  frame_done,
   output logic [DROP_BITS-1:0]  dropped_count
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [COORD_BITS-1:0] ONE = COORD_BITS'(1);
   localparam logic [COORD_BITS-1:0] TWO = COORD_BITS'(2);

   typedef struct packed {
      logic [COORD_BITS-1:0] x;
      logic [COORD_BITS-1:0] y;
      logic [SCORE_BITS-1:0] score;
   } rec_t;

   logic [COORD_BITS-1:0]        col_q, col_d, row_q, row_d;
   logic signed [SCORE_BITS-1:0] s_l_q, s_l_d, s_c_q, s_c_d;
   logic                         frame_done_q, frame_done_d;
   logic [DROP_BITS-1:0]         drop_q, drop_d;
   logic [AW-1:0]                wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]                count_q, count_d, old_left;
   logic                         out_valid_q, out_valid_d;
   rec_t                         out_rec_q, out_rec_d;
   rec_t                         mem_q [FIFO_DEPTH];

   logic signed [SCORE_BITS-1:0] s_in, thr_s;
   logic last_col, last_row, corner, full, push, pop;
   rec_t wr_rec;

   always_comb begin
      s_in     = bus.in_score;
      thr_s    = r_threshold;
      last_col = (col_q == r_row_length - ONE);
      last_row = (row_q == r_num_rows - ONE);

      // Candidate is column col-1; window s_l/s_c/s_in covers col-2..col.
      corner = bus.in_valid && (col_q >= TWO) && (row_q != '0) && !last_row &&
               (s_c_q > thr_s) && (s_c_q > s_l_q) && (s_c_q >= s_in);
      wr_rec = '{x: col_q - ONE, y: row_q, score: s_c_q};

      // Full is judged on the pre-edge occupancy, so a same-edge pop cannot make room.
      full = (count_q == CW'(FIFO_DEPTH));
      push = corner && !full;
      pop  = out_valid_q && bus.out_ready;

      count_d  = count_q + CW'(push) - CW'(pop);
      wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

      // Only entries written before this edge count toward visibility; a record
      // written now appears one edge later, always already resident in mem_q.
      old_left    = count_q - CW'(pop);
      out_valid_d = (old_left != '0);
      out_rec_d   = out_valid_d ? mem_q[rd_ptr_d] : out_rec_q;

      drop_d = drop_q;
      if (corner && full && (drop_q != '1)) drop_d = drop_q + DROP_BITS'(1);

      col_d        = col_q;
      row_d        = row_q;
      s_l_d        = s_l_q;
      s_c_d        = s_c_q;
      frame_done_d = 1'b0;
      if (bus.in_valid) begin
         if (last_col) begin
            col_d        = '0;
            row_d        = last_row ? '0 : row_q + ONE;
            frame_done_d = last_row;
         end else begin
            col_d = col_q + ONE;
         end
         // Column 0 starts a fresh window; nothing carries across rows.
         s_l_d = (col_q == '0) ? '0 : s_c_q;
         s_c_d = s_in;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         col_q        <= '0;
         row_q        <= '0;
         s_l_q        <= '0;
         s_c_q        <= '0;
         frame_done_q <= 1'b0;
         drop_q       <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         out_valid_q  <= 1'b0;
         out_rec_q    <= '0;
      end else begin
         col_q        <= col_d;
         row_q        <= row_d;
         s_l_q        <= s_l_d;
         s_c_q        <= s_c_d;
         frame_done_q <= frame_done_d;
         drop_q       <= drop_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         out_valid_q  <= out_valid_d;
         out_rec_q    <= out_rec_d;
      end
   end

   // Storage needs no reset: it is only read once the pointers say an entry is live.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= wr_rec;
   end

   assign bus.out_valid  = out_valid_q;
   assign bus.out_x      = out_rec_q.x;
   assign bus.out_y      = out_rec_q.y;
   assign bus.out_score  = out_rec_q.score;
   assign frame_done     = frame_done_q;
   assign dropped_count  = drop_q;
endmodule
